// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: requester drives start and operands,
// the adder returns busy/done and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: DIGIT bits per clock through a small ripple,
// carry held in a flop between digits, result valid on the one-cycle done pulse.
//
// state   | meaning
// IDLE    | waiting for start, result registers hold last answer
// RUN     | one digit per edge, cnt_q counts remaining digits down to 0
// DONE    | done pulse cycle; start here is accepted back-to-back
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $fatal(1, "serial_adder: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0] sum_dig;
  logic             c_out_dig;
  logic             c_msb_dig;

  always_comb begin : digit_ripple
    logic c;
    c         = carry_q;
    sum_dig   = '0;
    c_msb_dig = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_dig = c;
      sum_dig[i] = a_q[i] ^ b_q[i] ^ c;
      c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    c_out_dig = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            cnt_q   <= CW'(N - 1);
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          // new digit enters at the top so the first digit lands at bit 0 after N shifts
          s_q     <= (s_q >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
          carry_q <= c_out_dig;
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= c_out_dig;
            ovf_q   <= c_msb_dig ^ c_out_dig;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench: directed handshake/reset tests on an 8/1 adder plus random
// and corner sweeps on 8/4, 8/8 and 16/4, all against an arithmetic reference.
module tb_serial_adder;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  logic rst_n;
  logic rst_sw_n;
  bit   main_fin = 1'b0;

  function automatic logic [15:0] mask16(input int w);
    logic [16:0] m;
    m = (17'd1 << w) - 17'd1;
    return m[15:0];
  endfunction

  function automatic logic [15:0] corner(input int w, input int idx);
    logic [15:0] m;
    m = mask16(w);
    case (idx)
      0:       return 16'd0;
      1:       return m;
      2:       return 16'd1 << (w - 1);
      3:       return m >> 1;
      default: return 16'd1;
    endcase
  endfunction

  // {cout,s} = A + (sub ? ~B : B) + (sub ? 1 : cin); signed overflow from operand/result signs
  function automatic exp_t ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                     input logic sub, input logic cin);
    logic [16:0] m, aa, bb, sum;
    exp_t e;
    m   = (17'd1 << w) - 17'd1;
    aa  = {1'b0, a} & m;
    bb  = sub ? (~{1'b0, b} & m) : ({1'b0, b} & m);
    sum = aa + bb + {16'd0, (sub ? 1'b1 : cin)};
    e.s        = sum[15:0] & m[15:0];
    e.cout     = sum[w];
    e.ovf      = (aa[w-1] == bb[w-1]) && (e.s[w-1] != aa[w-1]);
    e.done_cyc = 0;
    return e;
  endfunction

  serial_adder_if #(.WIDTH(8)) m_bus ();
  serial_adder #(.WIDTH(8), .DIGIT(1)) u_main (.clk(clk), .rst_n(rst_n), .bus(m_bus));

  exp_t m_q[$];
  exp_t m_e;

  always @(negedge clk) begin
    if (m_bus.done) begin
      checks++;
      if (m_bus.busy) begin
        errors++;
        $display("FAIL main_busy_with_done busy=%b required 0", m_bus.busy);
      end
      if (m_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_unexpected_done s=%h cout=%b ovf=%b", m_bus.s, m_bus.cout, m_bus.ovf);
      end else begin
        m_e = m_q.pop_front();
        checks++;
        if ({m_bus.s, m_bus.cout, m_bus.ovf} !== {m_e.s[7:0], m_e.cout, m_e.ovf}) begin
          errors++;
          $display("FAIL main_result got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                   m_bus.s, m_bus.cout, m_bus.ovf, m_e.s[7:0], m_e.cout, m_e.ovf);
        end
        checks++;
        if (cyc != m_e.done_cyc) begin
          errors++;
          $display("FAIL main_latency got cycle %0d want %0d", cyc, m_e.done_cyc);
        end
      end
    end
  end

  task automatic m_issue(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic cin, input bit push, output int acc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (m_bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL main_issue_timeout busy=%b after %0d cycles", m_bus.busy, guard);
    end
    m_bus.start = 1'b1;
    m_bus.a     = a;
    m_bus.b     = b;
    m_bus.sub   = sub;
    m_bus.cin   = cin;
    acc = cyc + 1;
    if (push) begin
      exp_t e;
      e = ref_model(8, {8'd0, a}, {8'd0, b}, sub, cin);
      e.done_cyc = acc + 8;
      m_q.push_back(e);
    end
    @(negedge clk);
    m_bus.start = 1'b0;
  endtask

  task automatic m_wait_idle();
    int g;
    g = 0;
    while ((m_bus.busy || m_q.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= 200) begin
      errors++;
      $display("FAIL main_wait_idle_timeout busy=%b pending=%0d", m_bus.busy, m_q.size());
    end
  endtask

  task automatic check_res(input string name, input logic [7:0] s, input logic cout, input logic ovf);
    checks++;
    if ({m_bus.s, m_bus.cout, m_bus.ovf} !== {s, cout, ovf}) begin
      errors++;
      $display("FAIL %s got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
               name, m_bus.s, m_bus.cout, m_bus.ovf, s, cout, ovf);
    end
  endtask

  initial begin
    int acc, busy_cnt, done_cnt, done_at, g;
    exp_t e;
    m_bus.start = 1'b0;
    m_bus.sub   = 1'b0;
    m_bus.cin   = 1'b0;
    m_bus.a     = '0;
    m_bus.b     = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_bus.busy, m_bus.done, m_bus.s, m_bus.cout, m_bus.ovf} !== 12'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b s=%h cout=%b ovf=%b want all 0",
               m_bus.busy, m_bus.done, m_bus.s, m_bus.cout, m_bus.ovf);
    end

    m_issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, acc);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i <= 10; i++) begin
      if (m_bus.busy) busy_cnt++;
      if (m_bus.done) begin
        done_cnt++;
        done_at = i;
      end
      if (i < 10) @(negedge clk);
    end
    checks++;
    if (busy_cnt != 8) begin
      errors++;
      $display("FAIL busy_length got %0d want 8", busy_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_at != 8) begin
      errors++;
      $display("FAIL done_pulse got count=%0d at=%0d want count=1 at=8", done_cnt, done_at);
    end
    check_res("ff_plus_01", 8'h00, 1'b1, 1'b0);

    m_issue(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1, acc);
    m_wait_idle();
    check_res("7f_plus_01_cin", 8'h81, 1'b0, 1'b1);
    m_issue(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, acc);
    m_wait_idle();
    check_res("ff_plus_ff_cin", 8'hFF, 1'b1, 1'b0);
    m_issue(8'h05, 8'h07, 1'b1, 1'b1, 1'b1, acc);
    m_wait_idle();
    check_res("sub_05_07", 8'hFE, 1'b0, 1'b0);
    m_issue(8'h80, 8'h01, 1'b1, 1'b0, 1'b1, acc);
    m_wait_idle();
    check_res("sub_80_01", 8'h7F, 1'b1, 1'b1);

    m_issue(8'h11, 8'h22, 1'b0, 1'b0, 1'b1, acc);
    repeat (2) @(negedge clk);
    m_bus.start = 1'b1;
    m_bus.a     = 8'h55;
    m_bus.b     = 8'h66;
    @(negedge clk);
    m_bus.start = 1'b0;
    m_wait_idle();
    check_res("busy_start_ignored", 8'h33, 1'b0, 1'b0);

    m_issue(8'h01, 8'h02, 1'b0, 1'b0, 1'b1, acc);
    m_bus.start = 1'b1;
    m_bus.a     = 8'h10;
    m_bus.b     = 8'h20;
    m_bus.sub   = 1'b0;
    m_bus.cin   = 1'b0;
    e = ref_model(8, 16'h10, 16'h20, 1'b0, 1'b0);
    e.done_cyc = acc + 8 + 1 + 8;
    m_q.push_back(e);
    g = 0;
    while (cyc < acc + 9 && g < 50) begin
      @(negedge clk);
      g++;
    end
    m_bus.start = 1'b0;
    m_wait_idle();
    check_res("back_to_back", 8'h30, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_res("result_hold", 8'h30, 1'b0, 1'b0);
    end

    m_issue(8'h33, 8'h44, 1'b0, 1'b0, 1'b0, acc);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_bus.busy, m_bus.done, m_bus.s, m_bus.cout, m_bus.ovf} !== 12'd0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b s=%h cout=%b ovf=%b want all 0",
               m_bus.busy, m_bus.done, m_bus.s, m_bus.cout, m_bus.ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_issue(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, acc);
    m_wait_idle();
    check_res("after_reset", 8'h02, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      m_issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);
    end
    m_wait_idle();
    main_fin = 1'b1;
  end

  // parameter sweep: 0 -> 8/4, 1 -> 8/8, 2 -> 16/4
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W = (g == 2) ? 16 : 8;
    localparam int D = (g == 1) ? 8 : 4;
    localparam int N = W / D;

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .rst_n(rst_sw_n), .bus(bus));

    exp_t q[$];
    exp_t e_mon;
    bit   fin = 1'b0;

    always @(negedge clk) begin
      if (bus.done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sweep%0d_unexpected_done s=%h", g, bus.s);
        end else begin
          e_mon = q.pop_front();
          checks++;
          if ({bus.s, bus.cout, bus.ovf} !== {e_mon.s[W-1:0], e_mon.cout, e_mon.ovf}) begin
            errors++;
            $display("FAIL sweep%0d_result got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                     g, bus.s, bus.cout, bus.ovf, e_mon.s[W-1:0], e_mon.cout, e_mon.ovf);
          end
          checks++;
          if (cyc != e_mon.done_cyc) begin
            errors++;
            $display("FAIL sweep%0d_latency got cycle %0d want %0d", g, cyc, e_mon.done_cyc);
          end
        end
      end
    end

    initial begin
      logic [15:0] a, b;
      logic        sub, cin;
      int          acc, guard;
      exp_t        e;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      wait (rst_sw_n === 1'b1);
      for (int i = 0; i < 80; i++) begin
        if (i < 50) begin
          a   = corner(W, i % 5);
          b   = corner(W, (i / 5) % 5);
          sub = (i >= 25);
          cin = 1'(i % 2);
        end else begin
          a   = 16'($urandom) & mask16(W);
          b   = 16'($urandom) & mask16(W);
          sub = 1'($urandom);
          cin = 1'($urandom);
        end
        @(negedge clk);
        guard = 0;
        while (bus.busy && guard < 100) begin
          @(negedge clk);
          guard++;
        end
        bus.start = 1'b1;
        bus.a     = a[W-1:0];
        bus.b     = b[W-1:0];
        bus.sub   = sub;
        bus.cin   = cin;
        acc = cyc + 1;
        e = ref_model(W, a, b, sub, cin);
        e.done_cyc = acc + N;
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
      end
      guard = 0;
      while (q.size() != 0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (guard >= 200) begin
        errors++;
        $display("FAIL sweep%0d_drain_timeout pending=%0d want 0", g, q.size());
      end
      fin = 1'b1;
    end
  end

  initial begin
    int g;
    rst_sw_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_sw_n = 1'b1;
    g = 0;
    while (!(main_fin && g_sw[0].fin && g_sw[1].fin && g_sw[2].fin) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20000) begin
      checks++;
      errors++;
      $display("FAIL global_timeout main=%b sweep=%b%b%b want all 1",
               main_fin, g_sw[0].fin, g_sw[1].fin, g_sw[2].fin);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
